reg_bank: RTL and testbench

- Register file for the multicycle CPU datapath. It consumes the destination index selected by the register-destination mux (rt, rd, 29, 31 or the immediate-derived index) together with the write-back data.
- It supplies two source operands to the A/B operand registers.
- 32 entries × DATA_W. Two read ports are registered (1-cycle latency, write-first); one write port is synchronous.
- Register 0 is hardwired to zero. The stack-pointer register is preset on reset.

---
 rtl/reg_bank_pkg.sv | 21 ++
 rtl/reg_bank_rdport.sv | 35 +++
 rtl/reg_bank.sv | 59 +++++
 tb/tb_reg_bank.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared CPU constants: register-file geometry, well-known register indices and
// the register-destination mux selector encodings.
package reg_bank_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int NUM_REGS     = 32;
  localparam int REG_ZERO     = 0;
  localparam int REG_SP       = 29;
  localparam int REG_RA       = 31;
  localparam int SP_RESET_VAL = 227;

  // Selector of the mux that feeds WriteReg; kept here so mux and bank agree on 29/31.
  typedef enum logic [2:0] {
    REGDST_RT  = 3'd0,
    REGDST_RD  = 3'd1,
    REGDST_SP  = 3'd2,
    REGDST_RA  = 3'd3,
    REGDST_IMM = 3'd4
  } regdst_sel_e;

endpackage

// File: rtl/reg_bank_rdport.sv
// One registered read port: index-0 forcing, write-first bypass, output register.
module reg_bank_rdport
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rd_idx_i,
  input  logic [DATA_W-1:0]    entry_i,
  input  logic                 wr_en_i,
  input  logic [REG_IDX_W-1:0] wr_idx_i,
  input  logic [DATA_W-1:0]    wr_data_i,
  output logic [DATA_W-1:0]    rd_data_o
);

  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  // wr_en_i already excludes index 0, so a matching bypass can never hit register 0.
  always_comb begin
    rd_data_d = entry_i;
    if (rd_idx_i == REG_IDX_W'(REG_ZERO))
      rd_data_d = '0;
    else if (wr_en_i && (wr_idx_i == rd_idx_i))
      rd_data_d = wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/reg_bank.sv
// 32-entry register file: one synchronous write port, two registered write-first
// read ports, r0 hardwired to zero, stack pointer preset on reset.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SP_INDEX = REG_SP,
  parameter int SP_RESET = SP_RESET_VAL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RegWrite,
  input  logic [REG_IDX_W-1:0] WriteReg,
  input  logic [DATA_W-1:0]    WriteData,
  input  logic [REG_IDX_W-1:0] ReadReg1,
  input  logic [REG_IDX_W-1:0] ReadReg2,
  output logic [DATA_W-1:0]    ReadData1,
  output logic [DATA_W-1:0]    ReadData2
);

  localparam int NUM_RD = 2;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en;

  logic [NUM_RD-1:0][REG_IDX_W-1:0] rd_idx;
  logic [NUM_RD-1:0][DATA_W-1:0]    rd_data;

  assign wr_en = RegWrite && (WriteReg != REG_IDX_W'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
    end else if (wr_en) begin
      regs_q[WriteReg] <= WriteData;
    end
  end

  assign rd_idx[0] = ReadReg1;
  assign rd_idx[1] = ReadReg2;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_bank_rdport #(.DATA_W(DATA_W)) u_rdport (
      .clk       (clk),
      .reset     (reset),
      .rd_idx_i  (rd_idx[p]),
      .entry_i   (regs_q[rd_idx[p]]),
      .wr_en_i   (wr_en),
      .wr_idx_i  (WriteReg),
      .wr_data_i (WriteData),
      .rd_data_o (rd_data[p])
    );
  end

  assign ReadData1 = rd_data[0];
  assign ReadData2 = rd_data[1];

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: reset values, write/read, r0, bypass, reset priority,
// write-enable gating with random idle traffic and full sweeps.
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1, ReadReg2;
  logic [31:0] ReadData1, ReadData2;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_mem [32];

  reg_bank #(.DATA_W(32), .SP_INDEX(29), .SP_RESET(227)) dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0;

    // reset state
    step();
    check("rst_rd1", ReadData1, 32'h0);
    check("rst_rd2", ReadData2, 32'h0);
    reset = 1'b0;

    ReadReg1 = 5'd29; ReadReg2 = 5'd5;
    step();
    check("sp_reset", ReadData1, 32'd227);
    check("r5_reset", ReadData2, 32'h0);

    // write then read
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF;
    ReadReg1 = 5'd0; ReadReg2 = 5'd9;
    step();
    check("r9_unwritten", ReadData2, 32'h0);
    RegWrite = 1'b0; ReadReg1 = 5'd8; ReadReg2 = 5'd8;
    step();
    check("wr_rd1_r8", ReadData1, 32'hDEADBEEF);
    check("wr_rd2_r8", ReadData2, 32'hDEADBEEF);

    // register 0 immutable, no bypass on index 0
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    step();
    check("r0_same_cyc1", ReadData1, 32'h0);
    check("r0_same_cyc2", ReadData2, 32'h0);
    RegWrite = 1'b0;
    step();
    check("r0_later", ReadData1, 32'h0);

    // bypass on both ports
    RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 32'h11;
    step();
    RegWrite = 1'b0; ReadReg1 = 5'd31; ReadReg2 = 5'd31;
    step();
    check("r31_pre", ReadData1, 32'h11);
    RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 32'h400;
    step();
    check("byp_rd1", ReadData1, 32'h400);
    check("byp_rd2", ReadData2, 32'h400);
    RegWrite = 1'b0;
    step();
    check("byp_stored", ReadData1, 32'h400);

    // bypass on one port only
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h1234_5678;
    ReadReg1 = 5'd8; ReadReg2 = 5'd7;
    step();
    check("byp1_rd1_old", ReadData1, 32'hDEADBEEF);
    check("byp1_rd2_new", ReadData2, 32'h1234_5678);
    RegWrite = 1'b0;

    // reset priority: write dropped, all state cleared
    reset = 1'b1; RegWrite = 1'b1; WriteReg = 5'd29; WriteData = 32'h55;
    ReadReg1 = 5'd29; ReadReg2 = 5'd8;
    step();
    check("rstpri_rd1", ReadData1, 32'h0);
    check("rstpri_rd2", ReadData2, 32'h0);
    reset = 1'b0; RegWrite = 1'b0;
    step();
    check("rstpri_sp", ReadData1, 32'd227);
    check("rstpri_r8", ReadData2, 32'h0);

    // preload every entry, SP and RA included
    exp_mem[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      exp_mem[i] = {8'hC3, 16'h0, 3'b0, 5'(i)} ^ (32'h0101_0101 * i);
      RegWrite = 1'b1; WriteReg = 5'(i); WriteData = exp_mem[i];
      step();
    end
    RegWrite = 1'b0;

    // 100 idle cycles with random write index/data
    for (int c = 0; c < 100; c++) begin
      WriteReg  = 5'($urandom_range(0, 31));
      WriteData = $urandom();
      ReadReg1  = 5'($urandom_range(0, 31));
      ReadReg2  = 5'($urandom_range(0, 31));
      step();
    end

    // sweep reads on both ports
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
      WriteReg = 5'($urandom_range(0, 31)); WriteData = $urandom();
      step();
      check($sformatf("sweep1_r%0d", i), ReadData1, exp_mem[i]);
      check($sformatf("sweep2_r%0d", 31 - i), ReadData2, exp_mem[31 - i]);
    end

    // mid-operation reset leaves no residue
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(i);
      step();
      check($sformatf("postrst1_r%0d", i), ReadData1, (i == 29) ? 32'd227 : 32'h0);
      check($sformatf("postrst2_r%0d", i), ReadData2, (i == 29) ? 32'd227 : 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
